// File: rtl/apu_pkg.sv
// Shared constants and helpers for the APU noise-channel control logic.
package apu_pkg;

  typedef enum logic [1:0] {
    ADDR_NR41 = 2'd0,
    ADDR_NR42 = 2'd1,
    ADDR_NR43 = 2'd2,
    ADDR_NR44 = 2'd3
  } reg_addr_e;

  localparam int LEN_MAX = 64;

  // Bit n set means frame step n clocks the length counter (steps 0,2,4,6).
  localparam logic [7:0] LEN_STEP_MASK = 8'b0101_0101;
  localparam logic [2:0] ENV_STEP      = 3'd7;

  // Shifts above this value stop the LFSR clock entirely.
  localparam logic [3:0] SHIFT_MAX = 4'd13;

  function automatic logic [4:0] lfsr_base(input logic [2:0] r);
    lfsr_base = (r == 3'd0) ? 5'd2 : {r, 2'b00};
  endfunction

endpackage

// File: rtl/ch4_envelope.sv
// Noise-channel volume envelope: volume, envelope period counter, done latch.
module ch4_envelope (
  input  logic       dova_phi,
  input  logic       apu_reset,
  input  logic       trigger,
  input  logic       env_clk,
  input  logic [7:0] nr42,
  output logic [3:0] vol
);

  logic [2:0] env_cnt;
  logic       env_done;
  logic [2:0] env_period;
  logic       env_up;

  assign env_period = nr42[2:0];
  assign env_up     = nr42[3];

  always_ff @(posedge dova_phi or posedge apu_reset) begin
    if (apu_reset) begin
      vol      <= 4'd0;
      env_cnt  <= 3'd0;
      env_done <= 1'b0;
    end else if (trigger) begin
      vol      <= nr42[7:4];
      env_cnt  <= env_period;
      env_done <= 1'b0;
    end else if (env_clk && env_period != 3'd0 && !env_done) begin
      if (env_cnt > 3'd1) begin
        env_cnt <= env_cnt - 3'd1;
      end else begin
        // Counter expires: reload and attempt one volume step; saturate latches done.
        env_cnt <= env_period;
        if (env_up) begin
          if (vol == 4'hF) env_done <= 1'b1;
          else             vol      <= vol + 4'd1;
        end else begin
          if (vol == 4'h0) env_done <= 1'b1;
          else             vol      <= vol - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/ch4_sequencer.sv
// Noise-channel controller: NR41-NR44 registers, frame sequencer, length
// counter, LFSR clock divider and envelope; drives the channel-4 datapath.
module ch4_sequencer #(
  parameter int LEN_MAX = apu_pkg::LEN_MAX,
  parameter int DIV_W   = 22
) (
  input  logic       dova_phi,
  input  logic       apu_reset,
  input  logic       en_1m,
  input  logic       fs_tick,
  input  logic       wr_en,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       ch4_restart,
  output logic       lfsr_tick,
  output logic       lfsr_width7,
  output logic [3:0] ch4_vol,
  output logic       ch4_active,
  output logic       dac_en
);
  import apu_pkg::*;

  localparam int LW = $clog2(LEN_MAX + 1);

  logic [7:0]       nr42;
  logic [7:0]       nr43;
  logic             len_en;
  logic [LW-1:0]    length_cnt;
  logic [2:0]       fs_step;
  logic [DIV_W-1:0] div_cnt;

  logic             wr_nr41, wr_nr42, wr_nr43, wr_nr44;
  logic             trigger;
  logic             len_clk, env_clk;
  logic             div_run;
  logic [DIV_W-1:0] div_period;
  logic [LW-1:0]    len_load;

  assign wr_nr41 = wr_en && (addr == ADDR_NR41);
  assign wr_nr42 = wr_en && (addr == ADDR_NR42);
  assign wr_nr43 = wr_en && (addr == ADDR_NR43);
  assign wr_nr44 = wr_en && (addr == ADDR_NR44);
  assign trigger = wr_nr44 && wdata[7];

  // Decisions use the step value before this tick's increment.
  assign len_clk = fs_tick && LEN_STEP_MASK[fs_step];
  assign env_clk = fs_tick && (fs_step == ENV_STEP);

  assign div_period = DIV_W'(lfsr_base(nr43[2:0])) << nr43[7:4];
  assign div_run    = en_1m && ch4_active && (nr43[7:4] <= SHIFT_MAX);
  assign len_load   = LW'(LEN_MAX) - LW'(wdata[5:0]);

  assign dac_en      = |nr42[7:3];
  assign lfsr_width7 = nr43[3];

  always_ff @(posedge dova_phi or posedge apu_reset) begin
    if (apu_reset) begin
      nr42        <= 8'h00;
      nr43        <= 8'h00;
      len_en      <= 1'b0;
      length_cnt  <= '0;
      fs_step     <= 3'd0;
      div_cnt     <= '0;
      ch4_active  <= 1'b0;
      ch4_restart <= 1'b0;
      lfsr_tick   <= 1'b0;
    end else begin
      ch4_restart <= trigger;
      lfsr_tick   <= 1'b0;

      if (fs_tick) fs_step <= fs_step + 3'd1;
      if (wr_nr42) nr42    <= wdata;
      if (wr_nr43) nr43    <= wdata;
      if (wr_nr44) len_en  <= wdata[6];

      // A write or trigger in the same cycle as a length clock suppresses the decrement.
      if (wr_nr41) begin
        length_cnt <= len_load;
      end else if (trigger) begin
        if (length_cnt == '0) length_cnt <= LW'(LEN_MAX);
      end else if (len_clk && len_en && length_cnt != '0) begin
        length_cnt <= length_cnt - LW'(1);
      end

      if (len_clk && len_en && length_cnt == LW'(1) && !wr_nr41 && !trigger)
        ch4_active <= 1'b0;
      if (trigger)
        ch4_active <= dac_en;
      if (wr_nr42 && wdata[7:3] == 5'd0)
        ch4_active <= 1'b0;

      if (trigger) begin
        div_cnt <= div_period;
      end else if (div_run) begin
        if (div_cnt <= DIV_W'(1)) begin
          div_cnt   <= div_period;
          lfsr_tick <= 1'b1;
        end else begin
          div_cnt <= div_cnt - DIV_W'(1);
        end
      end
    end
  end

  ch4_envelope u_envelope (
    .dova_phi  (dova_phi),
    .apu_reset (apu_reset),
    .trigger   (trigger),
    .env_clk   (env_clk),
    .nr42      (nr42),
    .vol       (ch4_vol)
  );

  always_comb begin
    rdata = 8'hFF;
    case (addr)
      ADDR_NR41: rdata = 8'hFF;
      ADDR_NR42: rdata = nr42;
      ADDR_NR43: rdata = nr43;
      ADDR_NR44: rdata = {1'b1, len_en, 6'h3F};
      default:   rdata = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_ch4_sequencer.sv
// Self-checking bench for ch4_sequencer: scenario tasks with queue-based expectations.
module tb_ch4_sequencer;

  logic       dova_phi  = 1'b0;
  logic       apu_reset = 1'b1;
  logic       en_1m     = 1'b0;
  logic       fs_tick   = 1'b0;
  logic       wr_en     = 1'b0;
  logic [1:0] addr      = 2'd0;
  logic [7:0] wdata     = 8'h00;
  logic [7:0] rdata;
  logic       ch4_restart, lfsr_tick, lfsr_width7, ch4_active, dac_en;
  logic [3:0] ch4_vol;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_cnt = 0;
  int tb_step  = 0;
  int exp_q[$];

  ch4_sequencer #(.LEN_MAX(64), .DIV_W(22)) dut (
    .dova_phi    (dova_phi),
    .apu_reset   (apu_reset),
    .en_1m       (en_1m),
    .fs_tick     (fs_tick),
    .wr_en       (wr_en),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .ch4_restart (ch4_restart),
    .lfsr_tick   (lfsr_tick),
    .lfsr_width7 (lfsr_width7),
    .ch4_vol     (ch4_vol),
    .ch4_active  (ch4_active),
    .dac_en      (dac_en)
  );

  always #5 dova_phi = ~dova_phi;

  always @(negedge dova_phi) if (lfsr_tick === 1'b1) tick_cnt++;

  task automatic cyc();
    @(posedge dova_phi);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    wr_en = 1'b1; addr = a; wdata = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic fs();
    fs_tick = 1'b1;
    cyc();
    fs_tick = 1'b0;
    cyc();
    tb_step = (tb_step + 1) % 8;
  endtask

  task automatic strobe();
    en_1m = 1'b1;
    cyc();
    en_1m = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    int e;
    int t0;
    apu_reset = 1'b1;
    repeat (3) cyc();
    apu_reset = 1'b0;
    cyc();
    tb_step = 0;
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'hBF);
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (rdata !== 8'(e)) begin
        n_fail++;
        $display("FAIL reset_rdata addr=%0d got=%h exp=%h", a, rdata, 8'(e));
      end
    end
    n_checks++;
    if (ch4_vol !== 4'd0 || ch4_active !== 1'b0 || dac_en !== 1'b0 || ch4_restart !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs vol=%0d active=%b dac=%b restart=%b exp all 0",
               ch4_vol, ch4_active, dac_en, ch4_restart);
    end
    t0 = tick_cnt;
    repeat (20) strobe();
    n_checks++;
    if (tick_cnt - t0 !== 0) begin
      n_fail++;
      $display("FAIL reset_no_ticks got=%0d exp=0", tick_cnt - t0);
    end
  endtask

  task automatic test_length();
    int len;
    int e;
    wr(2'd1, 8'hF0);
    wr(2'd0, 8'h3E);
    wr(2'd3, 8'hC0);
    n_checks++;
    if (ch4_restart !== 1'b1 || ch4_active !== 1'b1 || ch4_vol !== 4'd15) begin
      n_fail++;
      $display("FAIL trigger_effect restart=%b active=%b vol=%0d exp 1 1 15",
               ch4_restart, ch4_active, ch4_vol);
    end
    addr = 2'd3; #1;
    n_checks++;
    if (rdata !== 8'hFF) begin
      n_fail++;
      $display("FAIL nr44_read got=%h exp=ff", rdata);
    end
    cyc();
    n_checks++;
    if (ch4_restart !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_width got=%b exp=0", ch4_restart);
    end
    len = 2;
    for (int i = 0; i < 4; i++) begin
      if (tb_step % 2 == 0 && len > 0) len--;
      exp_q.push_back(len != 0);
      fs();
      e = exp_q.pop_front();
      n_checks++;
      if (ch4_active !== 1'(e)) begin
        n_fail++;
        $display("FAIL length_active tick=%0d got=%b exp=%0d", i, ch4_active, e);
      end
    end
  endtask

  task automatic test_envelope();
    int env_clocks;
    int e;
    wr(2'd1, 8'h0B);
    wr(2'd3, 8'h80);
    n_checks++;
    if (ch4_vol !== 4'd0) begin
      n_fail++;
      $display("FAIL env_up_start got=%0d exp=0", ch4_vol);
    end
    env_clocks = 0;
    for (int i = 0; i < 400; i++) begin
      if (tb_step == 7) env_clocks++;
      exp_q.push_back((env_clocks / 3 > 15) ? 15 : env_clocks / 3);
      fs();
      e = exp_q.pop_front();
      n_checks++;
      if (ch4_vol !== 4'(e)) begin
        n_fail++;
        $display("FAIL env_up tick=%0d got=%0d exp=%0d", i, ch4_vol, e);
      end
    end
    wr(2'd1, 8'h31);
    wr(2'd3, 8'h80);
    env_clocks = 0;
    for (int i = 0; i < 40; i++) begin
      if (tb_step == 7) env_clocks++;
      exp_q.push_back((env_clocks >= 3) ? 0 : 3 - env_clocks);
      fs();
      e = exp_q.pop_front();
      n_checks++;
      if (ch4_vol !== 4'(e)) begin
        n_fail++;
        $display("FAIL env_down tick=%0d got=%0d exp=%0d", i, ch4_vol, e);
      end
    end
  endtask

  task automatic test_lfsr();
    int t0;
    int e;
    wr(2'd1, 8'hF0);
    wr(2'd2, 8'h11);
    wr(2'd3, 8'h80);
    addr = 2'd2; #1;
    n_checks++;
    if (rdata !== 8'h11 || lfsr_width7 !== 1'b0) begin
      n_fail++;
      $display("FAIL nr43_read got=%h w7=%b exp=11 0", rdata, lfsr_width7);
    end
    t0 = tick_cnt;
    for (int k = 1; k <= 40; k++) begin
      exp_q.push_back(k / 8);
      strobe();
      e = exp_q.pop_front();
      n_checks++;
      if (tick_cnt - t0 !== e) begin
        n_fail++;
        $display("FAIL lfsr_period8 strobe=%0d got=%0d exp=%0d", k, tick_cnt - t0, e);
      end
    end
    wr(2'd2, 8'hE8);
    n_checks++;
    if (lfsr_width7 !== 1'b1) begin
      n_fail++;
      $display("FAIL width7 got=%b exp=1", lfsr_width7);
    end
    t0 = tick_cnt;
    repeat (40) strobe();
    n_checks++;
    if (tick_cnt - t0 !== 0) begin
      n_fail++;
      $display("FAIL lfsr_s14 got=%0d exp=0", tick_cnt - t0);
    end
    wr(2'd2, 8'h00);
    wr(2'd3, 8'h80);
    t0 = tick_cnt;
    repeat (20) strobe();
    n_checks++;
    if (tick_cnt - t0 !== 10) begin
      n_fail++;
      $display("FAIL lfsr_period2 got=%0d exp=10", tick_cnt - t0);
    end
  endtask

  task automatic test_collision();
    int k;
    int lc;
    int e;
    wr(2'd1, 8'hF0);
    wr(2'd0, 8'h3F);
    wr(2'd3, 8'hC0);
    k = 0;
    while (ch4_active === 1'b1 && k < 4) begin
      fs();
      k++;
    end
    n_checks++;
    if (ch4_active !== 1'b0) begin
      n_fail++;
      $display("FAIL len1_expire_timeout active=%b exp=0", ch4_active);
    end
    while (tb_step != 0) fs();
    // Trigger lands on the same edge as a step-0 length clock.
    wr_en = 1'b1; addr = 2'd3; wdata = 8'hC0; fs_tick = 1'b1;
    cyc();
    wr_en = 1'b0; fs_tick = 1'b0;
    tb_step = 1;
    n_checks++;
    if (ch4_restart !== 1'b1 || ch4_active !== 1'b1) begin
      n_fail++;
      $display("FAIL coincident_trigger restart=%b active=%b exp 1 1", ch4_restart, ch4_active);
    end
    lc = 0;
    for (int i = 0; i < 140; i++) begin
      if (tb_step % 2 == 0) lc++;
      exp_q.push_back(lc < 64);
      fs();
      e = exp_q.pop_front();
      n_checks++;
      if (ch4_active !== 1'(e)) begin
        n_fail++;
        $display("FAIL reload64 tick=%0d got=%b exp=%0d", i, ch4_active, e);
      end
    end
    wr(2'd3, 8'h80);
    n_checks++;
    if (ch4_active !== 1'b1) begin
      n_fail++;
      $display("FAIL retrigger_active got=%b exp=1", ch4_active);
    end
    wr(2'd1, 8'h00);
    n_checks++;
    if (ch4_active !== 1'b0 || dac_en !== 1'b0) begin
      n_fail++;
      $display("FAIL dac_off active=%b dac=%b exp 0 0", ch4_active, dac_en);
    end
  endtask

  task automatic test_reset_mid();
    wr(2'd1, 8'h7A);
    wr(2'd3, 8'h80);
    n_checks++;
    if (ch4_vol !== 4'd7) begin
      n_fail++;
      $display("FAIL mid_vol_pre got=%0d exp=7", ch4_vol);
    end
    if (tb_step % 2 == 0) fs();
    apu_reset = 1'b1;
    addr = 2'd1;
    #2;
    n_checks++;
    if (ch4_vol !== 4'd0 || ch4_active !== 1'b0 || rdata !== 8'h00 || dac_en !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset vol=%0d active=%b nr42=%h dac=%b exp 0 0 00 0",
               ch4_vol, ch4_active, rdata, dac_en);
    end
    cyc();
    apu_reset = 1'b0;
    tb_step = 0;
    cyc();
    wr(2'd1, 8'h7A);
    wr(2'd0, 8'h3F);
    wr(2'd3, 8'hC0);
    n_checks++;
    if (ch4_vol !== 4'd7 || ch4_active !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_trigger vol=%0d active=%b exp 7 1", ch4_vol, ch4_active);
    end
    fs();
    n_checks++;
    if (ch4_active !== 1'b0) begin
      n_fail++;
      $display("FAIL first_step_is_len got=%b exp=0", ch4_active);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_length();
    test_envelope();
    test_lfsr();
    test_collision();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ch4_sequencer.md
# ch4_sequencer

Synchronous controller for the noise channel. It owns the NR41–NR44 register state, the frame-sequencer step counter, the length counter, the volume envelope and the LFSR clock divider. It sits between the CPU register bus and the channel-4 LFSR/amplitude datapath. It emits restart, shift-tick, width-select and 4-bit volume, which the datapath consumes.

## Interface
Parameters:
- LEN_MAX, 64, length counter full-scale value.
- DIV_W, 22, width of the LFSR divider counter. Must hold 112<<13.

Ports:
- dova_phi  in  1  APU clock; all state updates on its rising edge.
- apu_reset  in  1  asynchronous, active-high reset.
- en_1m  in  1  single-cycle strobe at the 1 MHz rate; the divider advances only when it is high.
- fs_tick  in  1  single-cycle 512 Hz frame-sequencer strobe.
- wr_en  in  1  register write strobe, one cycle.
- addr  in  2  register select: 0=FF20, 1=FF21, 2=FF22, 3=FF23.
- wdata  in  8  write data.
- rdata  out  8  read data for the selected register.
- ch4_restart  out  1  one-cycle trigger pulse to the datapath (LFSR reload).
- lfsr_tick  out  1  one-cycle LFSR shift strobe.
- lfsr_width7  out  1  NR43 bit 3; selects 7-bit LFSR mode.
- ch4_vol  out  4  current envelope volume.
- ch4_active  out  1  channel status for NR52 bit 3.
- dac_en  out  1  high when NR42[7:3] != 0.

## Operation
- Reset: all registers, counters and outputs go to 0, and the frame-sequencer step goes to 0.
- Frame sequencer: a 3-bit step counter increments on fs_tick and wraps 7→0.
  - Length clocks on steps 0, 2, 4 and 6, evaluated on the step value before the increment.
  - Envelope clocks on step 7.
- FF20 write: length_cnt <= LEN_MAX − wdata[5:0], giving a range of 1..64. A write of 0 loads 64.
- FF21 write: stores NR42. If wdata[7:3] == 0, dac_en falls and ch4_active clears in the same cycle.
- FF22 write: stores NR43 (shift s=[7:4], width=[3], r=[2:0]).
- FF23 write: stores len_en = wdata[6]. If wdata[7] is set, a trigger occurs, with these effects:
  - ch4_restart pulses for one cycle.
  - If length_cnt == 0, it is reloaded with 64.
  - vol <= NR42[7:4]; env_cnt <= NR42[2:0]; env_done <= 0.
  - The divider is reloaded with the full period.
  - ch4_active <= dac_en.
- Length clock: if len_en and length_cnt != 0, decrement length_cnt. On the transition to 0, ch4_active <= 0.
- Envelope clock: acts only if NR42[2:0] != 0 and env_done == 0.
  - env_cnt decrements. When it reaches 0, it reloads with NR42[2:0] and the volume steps.
  - Volume steps +1 if NR42[3], otherwise −1.
  - If the step would leave 0..15, the volume holds and env_done <= 1.
- LFSR divider:
  - Period in en_1m units = base(r) << s, where base(0)=2 and base(r)=4r.
  - On each en_1m, the counter decrements. At 1 it pulses lfsr_tick and reloads.
  - If s ≥ 14 or ch4_active == 0, lfsr_tick is suppressed and the counter holds.
- Readback:
  - FF20 reads 0xFF.
  - FF21 and FF22 read the stored value.
  - FF23 reads {1, len_en, 6'h3F}.
- Length obscura are not modelled: there is no extra length clock on enable or trigger during odd steps.

## Timing
- Write-to-effect latency is one cycle: the register value and its consequences are visible on the edge after wr_en.
- ch4_restart is high exactly in the cycle after the FF23 trigger write.
- Simultaneous events:
  - Trigger vs length clock in the same cycle: the trigger wins, so length_cnt = reload value and is not decremented.
  - FF20 write vs length clock: the write wins.
  - Trigger vs envelope clock: the trigger wins, so vol = NR42[7:4].
  - FF21 write with DAC off vs trigger: ch4_active = 0.
- Boundaries:
  - At vol 15 with direction up, or vol 0 with direction down, the volume holds and env_done latches.
  - length_cnt is never decremented below 0.
  - The step counter wraps with no missed envelope tick.
- apu_reset asserted mid-operation: every state bit clears asynchronously. The first fs_tick after release is treated as step 0.

## Structure
- apu_pkg holds:
  - the register-address enum (NR41..NR44);
  - LEN_MAX;
  - a function computing base(r);
  - the frame-step constants (length steps, ENV_STEP=7).
- There is one sub-module, ch4_envelope: volume, env_cnt and env_done, with inputs trigger, env_clk, nr42. It is instantiated once here.

## Test plan
- Reset, then read FF21/22/23 → 0x00, 0x00, 0xBF. ch4_vol=0, ch4_active=0, lfsr_tick never pulses.
- NR42=0xF0, FF20=0x3E, NR44=0xC0 → ch4_restart for one cycle, active=1, vol=15. After 2 length clocks (4 fs_ticks) active=0.
- NR42=0x0B (up, period 3), trigger → vol 0→1 after 3 envelope steps (24 fs_ticks). Saturates at 15, then env_done holds.
- NR43=0x11 (r=1, s=1) → period 8, lfsr_tick every 8 en_1m strobes. NR43=0xE0 → no ticks.
- Trigger coincident with a step-0 fs_tick, with length_cnt=0 → length_cnt=64, no decrement. Then NR42=0x00 → active falls on the next cycle.
- Assert apu_reset mid-envelope (vol=7) → vol=0 and step=0 immediately. After release, NR44 trigger restores NR42 volume.
